// File: rtl/uart_order_parser.sv
// Order framer behind the UART receiver: 7-byte frames (sync, cmd, price, qty, xor csum) -> decoded order.
// Latency: order fields and ord_valid register one cycle after the checksum byte strobe; error pulses one cycle after cause.
// Backpressure: none on input (every strobe consumed); output holds until ord_ready, good frames arriving meanwhile are dropped with err_overflow.
module uart_order_parser #(
   parameter int unsigned CLK_FREQ      = 50000000,
   parameter int unsigned BAUD_RATE     = 115200,
   parameter int unsigned TIMEOUT_BYTES = 4,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        ord_side,
   output logic [15:0] ord_price,
   output logic [15:0] ord_qty,
   output logic        ord_valid,
   input  logic        ord_ready,
   output logic        err_checksum,
   output logic        err_format,
   output logic        err_timeout,
   output logic        err_overflow
);

   // One byte on the line is start + 8 data + stop = 10 bit-times.
   localparam int unsigned CLK_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam logic [31:0] GAP_LIMIT   = 32'(TIMEOUT_BYTES * 10 * CLK_PER_BIT);

   localparam logic [7:0] CMD_BUY  = 8'h42;
   localparam logic [7:0] CMD_SELL = 8'h53;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_CMD,
      ST_PRICE_HI,
      ST_PRICE_LO,
      ST_QTY_HI,
      ST_QTY_LO,
      ST_CSUM
   } state_t;

   // Frame-assembly state
   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [7:0]  csum_q, csum_d;
   logic        side_sh_q, side_sh_d;
   logic [15:0] price_sh_q, price_sh_d;
   logic [15:0] qty_sh_q, qty_sh_d;

   // Output-side state
   logic        ord_valid_q, ord_valid_d;
   logic        ord_side_q, ord_side_d;
   logic [15:0] ord_price_q, ord_price_d;
   logic [15:0] ord_qty_q, ord_qty_d;

   // Error pulse registers
   logic        err_checksum_q, err_checksum_d;
   logic        err_format_q, err_format_d;
   logic        err_timeout_q, err_timeout_d;
   logic        err_overflow_q, err_overflow_d;

   // A fully validated frame is ready to be handed to the output stage this cycle.
   logic        commit_req;
   logic        can_load;

   // Next-state, gap timer and shadow-field assembly for the frame FSM.
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      csum_d         = csum_q;
      side_sh_d      = side_sh_q;
      price_sh_d     = price_sh_q;
      qty_sh_d       = qty_sh_q;
      err_checksum_d = 1'b0;
      err_format_d   = 1'b0;
      err_timeout_d  = 1'b0;
      commit_req     = 1'b0;

      // Gap timer: idle while hunting, restarted by every byte. A byte that
      // lands on the limit cycle takes precedence over the timeout.
      if (state_q == ST_HUNT) begin
         timer_d = '0;
      end else if (in_valid) begin
         timer_d = '0;
      end else if (timer_q == GAP_LIMIT) begin
         timer_d       = '0;
         err_timeout_d = 1'b1;
         state_d       = ST_HUNT;
      end else begin
         timer_d = timer_q + 32'd1;
      end

      if (in_valid) begin
         unique case (state_q)
            ST_HUNT: begin
               if (in_data == SYNC_BYTE) begin
                  csum_d  = '0;
                  state_d = ST_CMD;
               end
            end
            ST_CMD: begin
               // An illegal command abandons the frame; the byte is not
               // re-examined as a possible sync, even if it equals one.
               if (in_data == CMD_BUY) begin
                  side_sh_d = 1'b0;
                  csum_d    = in_data;
                  state_d   = ST_PRICE_HI;
               end else if (in_data == CMD_SELL) begin
                  side_sh_d = 1'b1;
                  csum_d    = in_data;
                  state_d   = ST_PRICE_HI;
               end else begin
                  err_format_d = 1'b1;
                  state_d      = ST_HUNT;
               end
            end
            ST_PRICE_HI: begin
               price_sh_d = {price_sh_q[7:0], in_data};
               csum_d     = csum_q ^ in_data;
               state_d    = ST_PRICE_LO;
            end
            ST_PRICE_LO: begin
               price_sh_d = {price_sh_q[7:0], in_data};
               csum_d     = csum_q ^ in_data;
               state_d    = ST_QTY_HI;
            end
            ST_QTY_HI: begin
               qty_sh_d = {qty_sh_q[7:0], in_data};
               csum_d   = csum_q ^ in_data;
               state_d  = ST_QTY_LO;
            end
            ST_QTY_LO: begin
               qty_sh_d = {qty_sh_q[7:0], in_data};
               csum_d   = csum_q ^ in_data;
               state_d  = ST_CSUM;
            end
            ST_CSUM: begin
               // Checksum failure outranks the zero-quantity check.
               state_d = ST_HUNT;
               if (in_data != csum_q) begin
                  err_checksum_d = 1'b1;
               end else if (qty_sh_q == 16'd0) begin
                  err_format_d = 1'b1;
               end else begin
                  commit_req = 1'b1;
               end
            end
            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end
   end

   assign can_load = !ord_valid_q || ord_ready;

   // Output holding register: clears on handshake, reloads on commit when free.
   always_comb begin
      ord_valid_d    = ord_valid_q && !ord_ready;
      ord_side_d     = ord_side_q;
      ord_price_d    = ord_price_q;
      ord_qty_d      = ord_qty_q;
      err_overflow_d = 1'b0;

      if (commit_req) begin
         if (can_load) begin
            ord_valid_d = 1'b1;
            ord_side_d  = side_sh_q;
            ord_price_d = price_sh_q;
            ord_qty_d   = qty_sh_q;
         end else begin
            // Held order has priority; the new frame is lost.
            err_overflow_d = 1'b1;
         end
      end
   end

   // Frame FSM, timer and shadow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_HUNT;
         timer_q        <= '0;
         csum_q         <= '0;
         side_sh_q      <= 1'b0;
         price_sh_q     <= '0;
         qty_sh_q       <= '0;
         err_checksum_q <= 1'b0;
         err_format_q   <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         csum_q         <= csum_d;
         side_sh_q      <= side_sh_d;
         price_sh_q     <= price_sh_d;
         qty_sh_q       <= qty_sh_d;
         err_checksum_q <= err_checksum_d;
         err_format_q   <= err_format_d;
         err_timeout_q  <= err_timeout_d;
      end
   end

   // Output order registers and overflow pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ord_valid_q    <= 1'b0;
         ord_side_q     <= 1'b0;
         ord_price_q    <= '0;
         ord_qty_q      <= '0;
         err_overflow_q <= 1'b0;
      end else begin
         ord_valid_q    <= ord_valid_d;
         ord_side_q     <= ord_side_d;
         ord_price_q    <= ord_price_d;
         ord_qty_q      <= ord_qty_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   assign ord_valid    = ord_valid_q;
   assign ord_side     = ord_side_q;
   assign ord_price    = ord_price_q;
   assign ord_qty      = ord_qty_q;
   assign err_checksum = err_checksum_q;
   assign err_format   = err_format_q;
   assign err_timeout  = err_timeout_q;
   assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_uart_order_parser.sv
// Directed bench for uart_order_parser: hand-computed frames, errors, stall, timeout and reset.
// Inputs driven 1ns after posedge; outputs sampled on negedge.
// ord_ready driven per scenario to exercise hold and overflow.
module tb_uart_order_parser;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        ord_side;
   logic [15:0] ord_price;
   logic [15:0] ord_qty;
   logic        ord_valid;
   logic        ord_ready;
   logic        err_checksum;
   logic        err_format;
   logic        err_timeout;
   logic        err_overflow;

   int n_checks = 0;
   int n_errors = 0;

   // Monitor counters
   int          n_acc, n_cs, n_fmt, n_tmo, n_ovf, n_multi;
   logic        acc_side;
   logic [15:0] acc_price, acc_qty;

   uart_order_parser #(
      .CLK_FREQ     (1000000),
      .BAUD_RATE    (100000),
      .TIMEOUT_BYTES(2),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .ord_side    (ord_side),
      .ord_price   (ord_price),
      .ord_qty     (ord_qty),
      .ord_valid   (ord_valid),
      .ord_ready   (ord_ready),
      .err_checksum(err_checksum),
      .err_format  (err_format),
      .err_timeout (err_timeout),
      .err_overflow(err_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record handshakes and error pulses away from the active edge.
   always @(negedge clk) begin
      if (ord_valid && ord_ready) begin
         n_acc     = n_acc + 1;
         acc_side  = ord_side;
         acc_price = ord_price;
         acc_qty   = ord_qty;
      end
      if (err_checksum) n_cs  = n_cs + 1;
      if (err_format)   n_fmt = n_fmt + 1;
      if (err_timeout)  n_tmo = n_tmo + 1;
      if (err_overflow) n_ovf = n_ovf + 1;
      if ((32'(err_checksum) + 32'(err_format) + 32'(err_timeout) + 32'(err_overflow)) > 1)
         n_multi = n_multi + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      n_acc = 0; n_cs = 0; n_fmt = 0; n_tmo = 0; n_ovf = 0;
      acc_side = 1'b0; acc_price = '0; acc_qty = '0;
   endtask

   // Drive n bytes (MSB first of v) on consecutive cycles; leaves in_valid high.
   task automatic send(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         in_data  = v[8*(n-1-i) +: 8];
         in_valid = 1'b1;
      end
   endtask

   // The posedge here captures the last byte; returns 1ns after it.
   task automatic send_end();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic frame(input logic [55:0] f);
      send({8'h00, f}, 7);
      send_end();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   localparam logic [55:0] F_BUY   = 56'hA5_42_01_2C_00_0A_65;  // buy 300 x 10
   localparam logic [55:0] F_SELL  = 56'hA5_53_00_64_00_05_32;  // sell 100 x 5
   localparam logic [55:0] F_BADCS = 56'hA5_42_01_2C_00_0A_66;
   localparam logic [55:0] F_ZQTY  = 56'hA5_42_00_10_00_00_52;
   localparam logic [55:0] F_SYNCD = 56'hA5_53_A5_00_00_01_F7;  // sync value as price data

   int tmo_at;

   initial begin
      rst_n     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      ord_ready = 1'b0;
      n_multi   = 0;
      clear_mon();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(ord_valid), 32'd0);
      check("rst_fields", {15'd0, ord_side, ord_price}, 32'd0);
      check("rst_qty", 32'(ord_qty), 32'd0);
      check("rst_errs", {28'd0, err_checksum, err_format, err_timeout, err_overflow}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // Buy frame, consumer ready: one-cycle ord_valid the cycle after CSUM
      ord_ready = 1'b1;
      clear_mon();
      frame(F_BUY);
      @(negedge clk);
      check("buy_valid_lat", 32'(ord_valid), 32'd1);
      @(negedge clk);
      check("buy_valid_drop", 32'(ord_valid), 32'd0);
      idle(2);
      check("buy_acc", n_acc, 1);
      check("buy_fields", {acc_side, acc_price, acc_qty[14:0]}, {1'b0, 16'd300, 15'd10});
      check("buy_errs", n_cs + n_fmt + n_tmo + n_ovf, 0);

      // Stall: sell held, buy dropped as overflow, then handshake
      ord_ready = 1'b0;
      clear_mon();
      frame(F_SELL);
      @(negedge clk);
      check("sell_held_valid", 32'(ord_valid), 32'd1);
      check("sell_held_fields", {ord_side, ord_price, ord_qty[14:0]}, {1'b1, 16'd100, 15'd5});
      idle(3);
      frame(F_BUY);
      @(negedge clk);
      check("ovf_pulse", 32'(err_overflow), 32'd1);
      check("ovf_held_fields", {ord_valid, ord_side, ord_price, ord_qty[13:0]}, {1'b1, 1'b1, 16'd100, 14'd5});
      @(posedge clk); #1;
      ord_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ovf_after_hs", 32'(ord_valid), 32'd0);
      check("ovf_acc", {n_acc[15:0], acc_price}, {16'd1, 16'd100});
      check("ovf_cnt", n_ovf, 1);

      // Bad checksum
      clear_mon();
      frame(F_BADCS);
      @(negedge clk);
      check("cs_pulse", 32'(err_checksum), 32'd1);
      idle(3);
      check("cs_no_order", n_acc, 0);

      // Bad command, then a valid frame still decodes
      clear_mon();
      send(64'hA558, 2);
      send_end();
      @(negedge clk);
      check("cmd_fmt_pulse", 32'(err_format), 32'd1);
      frame(F_BUY);
      idle(3);
      check("cmd_recover", {n_acc[15:0], acc_price}, {16'd1, 16'd300});

      // Sync byte in the CMD slot is a format error, not a resync; the rest is ignored
      clear_mon();
      frame(56'hA5_A5_42_01_2C_00_0A);
      send(8'h65, 1);
      send_end();
      idle(3);
      check("cmd_sync_fmt", n_fmt, 1);
      check("cmd_sync_noacc", n_acc, 0);

      // Zero quantity
      clear_mon();
      frame(F_ZQTY);
      @(negedge clk);
      check("zqty_fmt", 32'(err_format), 32'd1);
      idle(3);
      check("zqty_noacc", n_acc, 0);

      // Sync value mid-frame is plain data
      clear_mon();
      frame(F_SYNCD);
      idle(3);
      check("syncdata_acc", n_acc, 1);
      check("syncdata_fields", {acc_side, acc_price, acc_qty[14:0]}, {1'b1, 16'hA500, 15'd1});

      // Back-to-back frames with no dead cycle
      clear_mon();
      send({8'h00, F_BUY}, 7);
      send({8'h00, F_SELL}, 7);
      send_end();
      idle(3);
      check("b2b_acc", n_acc, 2);
      check("b2b_last", {acc_side, acc_price, acc_qty[14:0]}, {1'b1, 16'd100, 15'd5});

      // Timeout: GAP_LIMIT = 2*10*10 = 200. Timer is 200 after the 200th idle
      // edge; the next idle edge raises the pulse, seen at negedge 201/202.
      clear_mon();
      tmo_at = 0;
      send(64'hA542, 2);
      send_end();
      for (int k = 1; k <= 250; k++) begin
         @(negedge clk);
         if (err_timeout && tmo_at == 0) tmo_at = k;
      end
      check("tmo_cnt", n_tmo, 1);
      check("tmo_window", 32'((tmo_at >= 201) && (tmo_at <= 202)), 32'd1);
      @(posedge clk); #1;
      send(64'h00FF, 2);
      frame(F_BUY);
      idle(3);
      check("tmo_noise_recover", {n_acc[15:0], acc_price}, {16'd1, 16'd300});

      // Byte arriving on the limit cycle wins over the timeout
      clear_mon();
      send(64'hA5, 1);
      send_end();
      repeat (199) @(posedge clk);
      send(64'h42012C000A65, 6);
      send_end();
      idle(3);
      check("limit_byte_wins_tmo", n_tmo, 0);
      check("limit_byte_wins_acc", n_acc, 1);

      // Reset mid-frame with an order held
      ord_ready = 1'b0;
      clear_mon();
      frame(F_SELL);
      send(64'hA54201, 3);
      @(posedge clk); #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("amid_rst_outs", {ord_valid, ord_side, ord_price, err_checksum, err_format, err_timeout, err_overflow},
            {1'b0, 1'b0, 16'd0, 4'd0});
      check("amid_rst_qty", 32'(ord_qty), 32'd0);
      idle(2);
      rst_n = 1'b1;
      ord_ready = 1'b1;
      send(64'h000A65, 3);
      send_end();
      idle(3);
      check("rst_partial_dropped", n_acc + n_cs + n_fmt, 0);
      frame(F_BUY);
      idle(3);
      check("rst_recover", {n_acc[15:0], acc_price}, {16'd1, 16'd300});

      check("single_err_per_cycle", n_multi, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
